// File: rtl/recovery_ctrl.sv
// rtl/recovery_ctrl.sv - mispredict recovery sequencer: flush/redirect, youngest-first ROB walk, tail restore
// Optional perf counters enabled by RECOVERY_PERF_EN.
module recovery_ctrl #(
  parameter int ROB_DEPTH = 32,
  parameter int ROB_W     = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mispredict_i,
  input  logic [31:0]      target_pc_i,
  input  logic [ROB_W-1:0] recover_tag_i,
  input  logic [ROB_W-1:0] rob_tail_i,
  output logic             flush_o,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  output logic             walk_valid_o,
  output logic [ROB_W-1:0] walk_idx_o,
  output logic             tail_restore_valid_o,
  output logic [ROB_W-1:0] tail_restore_o,
`ifdef RECOVERY_PERF_EN
  output logic [31:0]      perf_recov_cnt_o,
  output logic [31:0]      perf_walk_cnt_o,
`endif
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, FLUSH, WALK, DONE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      tgt, tgt_nxt;
  logic [ROB_W-1:0] stop, stop_nxt;
  logic [ROB_W-1:0] idx, idx_nxt;
  logic [ROB_W-1:0] tail, tail_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      tgt   <= '0;
      stop  <= '0;
      idx   <= '0;
      tail  <= '0;
    end else begin
      state <= state_nxt;
      tgt   <= tgt_nxt;
      stop  <= stop_nxt;
      idx   <= idx_nxt;
      tail  <= tail_nxt;
    end
  end

  // Outputs decode only registered state, so nothing reaches them combinationally from inputs.
  always_comb begin
    state_nxt            = state;
    tgt_nxt              = tgt;
    stop_nxt             = stop;
    idx_nxt              = idx;
    tail_nxt             = tail;
    flush_o              = 1'b0;
    redirect_valid_o     = 1'b0;
    redirect_pc_o        = '0;
    walk_valid_o         = 1'b0;
    walk_idx_o           = '0;
    tail_restore_valid_o = 1'b0;
    tail_restore_o       = '0;
    busy_o               = (state != IDLE);
    case (state)
      IDLE: begin
        if (mispredict_i) begin
          tgt_nxt   = target_pc_i;
          stop_nxt  = recover_tag_i + ROB_W'(1);
          idx_nxt   = rob_tail_i - ROB_W'(1);
          tail_nxt  = rob_tail_i;
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        flush_o          = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = tgt;
        // tail == tag+1 means no entry is younger than the branch.
        state_nxt        = (tail != stop) ? WALK : DONE;
      end
      WALK: begin
        walk_valid_o = 1'b1;
        walk_idx_o   = idx;
        if (idx == stop) state_nxt = DONE;
        else             idx_nxt   = idx - ROB_W'(1);
      end
      DONE: begin
        tail_restore_valid_o = 1'b1;
        tail_restore_o       = stop;
        state_nxt            = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef RECOVERY_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_recov_cnt_o <= '0;
      perf_walk_cnt_o  <= '0;
    end else begin
      if (state == FLUSH) perf_recov_cnt_o <= perf_recov_cnt_o + 32'd1;
      if (state == WALK)  perf_walk_cnt_o  <= perf_walk_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_recovery_ctrl.sv
// tb/tb_recovery_ctrl.sv - scoreboard bench for recovery_ctrl
module tb_recovery_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mispredict_i;
  logic [31:0] target_pc_i;
  logic [4:0]  recover_tag_i;
  logic [4:0]  rob_tail_i;
  logic        flush_o, redirect_valid_o, walk_valid_o, tail_restore_valid_o, busy_o;
  logic [31:0] redirect_pc_o;
  logic [4:0]  walk_idx_o, tail_restore_o;
`ifdef RECOVERY_PERF_EN
  logic [31:0] perf_recov_cnt_o, perf_walk_cnt_o;
`endif

  recovery_ctrl #(.ROB_DEPTH(32), .ROB_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .mispredict_i(mispredict_i), .target_pc_i(target_pc_i),
    .recover_tag_i(recover_tag_i), .rob_tail_i(rob_tail_i), .flush_o(flush_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .walk_valid_o(walk_valid_o), .walk_idx_o(walk_idx_o),
    .tail_restore_valid_o(tail_restore_valid_o), .tail_restore_o(tail_restore_o),
`ifdef RECOVERY_PERF_EN
    .perf_recov_cnt_o(perf_recov_cnt_o), .perf_walk_cnt_o(perf_walk_cnt_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 flush/redirect, 1 walk, 2 tail restore
    logic [31:0] val;
    int          cyc;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  total = 0;
  int  passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  initial begin : monitor
    ev_t e;
    int  kind;
    logic [31:0] val;
    forever begin
      @(negedge clk);
      check("busy_vs_active", {31'd0, busy_o}, {31'd0, flush_o | walk_valid_o | tail_restore_valid_o});
      check("redirect_with_flush", {31'd0, redirect_valid_o}, {31'd0, flush_o});
      if (flush_o || walk_valid_o || tail_restore_valid_o) begin
        kind = flush_o ? 0 : (walk_valid_o ? 1 : 2);
        val  = flush_o ? redirect_pc_o : (walk_valid_o ? {27'd0, walk_idx_o} : {27'd0, tail_restore_o});
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_event actual=kind%0d/0x%0h required=none (cycle %0d)", kind, val, cyc);
        end else begin
          e = sb.pop_front();
          check("event_kind", kind, e.kind);
          check("event_value", val, e.val);
          check("event_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // keep_walks < 0 expects the full sequence; otherwise only flush plus the first keep_walks walk entries.
  task automatic issue(input logic [4:0] tag, input logic [4:0] tail, input logic [31:0] tgt,
                       input int keep_walks);
    int t0, n, lim;
    ev_t e;
    t0 = cyc;
    mispredict_i  = 1'b1;
    recover_tag_i = tag;
    rob_tail_i    = tail;
    target_pc_i   = tgt;
    n = (int'(tail) - int'(tag) - 1 + 64) % 32;
    e.kind = 0; e.val = tgt; e.cyc = t0 + 1; sb.push_back(e);
    lim = (keep_walks < 0) ? n : keep_walks;
    for (int k = 0; k < lim; k++) begin
      e.kind = 1; e.val = 32'((int'(tail) - 1 - k + 64) % 32); e.cyc = t0 + 2 + k; sb.push_back(e);
    end
    if (keep_walks < 0) begin
      e.kind = 2; e.val = 32'((int'(tag) + 1) % 32); e.cyc = t0 + 2 + n; sb.push_back(e);
    end
    step();
    mispredict_i  = 1'b0;
    rob_tail_i    = tail ^ 5'h15;
    target_pc_i   = ~tgt;
    recover_tag_i = ~tag;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      step();
      k++;
    end
    check("drain_empty", sb.size(), 0);
    step();
    check("idle_after_done", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic check_all_zero(input string tagname);
    check({tagname, "_flush"}, {31'd0, flush_o}, 32'd0);
    check({tagname, "_redir_v"}, {31'd0, redirect_valid_o}, 32'd0);
    check({tagname, "_redir_pc"}, redirect_pc_o, 32'd0);
    check({tagname, "_walk_v"}, {31'd0, walk_valid_o}, 32'd0);
    check({tagname, "_walk_idx"}, {27'd0, walk_idx_o}, 32'd0);
    check({tagname, "_tr_v"}, {31'd0, tail_restore_valid_o}, 32'd0);
    check({tagname, "_tr"}, {27'd0, tail_restore_o}, 32'd0);
    check({tagname, "_busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin : main
`ifdef RECOVERY_PERF_EN
    logic [31:0] base_r, base_w;
`endif
    rst_n = 1'b0; mispredict_i = 1'b0; target_pc_i = '0; recover_tag_i = '0; rob_tail_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
`ifdef RECOVERY_PERF_EN
    check("reset_perf_recov", perf_recov_cnt_o, 32'd0);
    check("reset_perf_walk", perf_walk_cnt_o, 32'd0);
`endif
    rst_n = 1'b1;
    step();

    issue(5'd5, 5'd9, 32'h0000_0100, -1);
    drain();

    // Second mispredict during WALK is dropped, then accepted when re-raised in IDLE.
    issue(5'd5, 5'd9, 32'h0000_0100, -1);
    step();
    mispredict_i = 1'b1; recover_tag_i = 5'd7; rob_tail_i = 5'd20; target_pc_i = 32'hdead_beef;
    step();
    mispredict_i = 1'b0;
    drain();
    issue(5'd7, 5'd12, 32'h0000_0200, -1);
    drain();

    issue(5'd3, 5'd4, 32'h0000_0044, -1);
    drain();
    issue(5'd30, 5'd2, 32'h0000_3000, -1);
    drain();
    issue(5'd10, 5'd10, 32'h1234_5678, -1);
    drain();
    issue(5'd0, 5'd0, 32'hffff_fffe, -1);
    drain();

`ifdef RECOVERY_PERF_EN
    base_r = perf_recov_cnt_o;
    base_w = perf_walk_cnt_o;
`endif
    issue(5'd5, 5'd9, 32'h0000_0100, -1);
    drain();
    issue(5'd30, 5'd2, 32'h0000_3000, -1);
    drain();
`ifdef RECOVERY_PERF_EN
    check("perf_recov_delta", perf_recov_cnt_o - base_r, 32'd2);
    check("perf_walk_delta", perf_walk_cnt_o - base_w, 32'd6);
`endif

    // Reset in the middle of a walk: no tail restore may follow.
    issue(5'd5, 5'd9, 32'h0000_0100, 2);
    step();
    step();
    rst_n = 1'b0;
    step();
    check_all_zero("midwalk_reset");
    rst_n = 1'b1;
    repeat (10) step();
    check("post_reset_sb_empty", sb.size(), 0);
    check("post_reset_busy", {31'd0, busy_o}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
